// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and board defaults.
// Imported by every file of the debounce block.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        COUNT_HI  = 2'b01,
        STABLE_HI = 2'b10,
        COUNT_LO  = 2'b11
    } state_e;

    // 10 ms of stability at the 25 MHz board clock.
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;

endpackage : debounce_pkg

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for asynchronous pad inputs; all stages reset to zero.
// Generic in width so other pad inputs can share it.
module sync_ff
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: the stage array is a handful of flops, not a RAM, so every entry is reset; a
    // true memory would be left unreset and initialised by its users instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : sync_ff

// File: rtl/switch_debounce.sv
// Bouncing board switch conditioner: synchroniser, stability-timer FSM, registered
// level output and one-cycle press/release strobes.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             switch_q;
    logic             press_q;
    logic             release_q;
    logic             busy_q;

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_n),
        .d_i    (i_Switch),
        .q_o    (sync_q)
    );

    // The counter only runs inside COUNT_* and tops out at CNT_LAST, so it never wraps;
    // every state change clears or reloads it.
    // NOTE: all state here is updated with non-blocking assignments so every register in
    // this block reads the pre-edge value of the others, whatever the statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (sync_q) begin
                        state_q <= COUNT_HI;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT_HI: begin
                    if (!sync_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= STABLE_HI;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        switch_q <= 1'b1;
                        press_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync_q) begin
                        state_q <= COUNT_LO;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT_LO: begin
                    if (sync_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= STABLE_LO;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        switch_q  <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign o_Switch  = switch_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Busy    = busy_q;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with DEBOUNCE_LIMIT=8, SYNC_STAGES=2:
// directed reset/latency sequences, a table of hold/bounce vectors and a random soak.
module tb_switch_debounce;
    import debounce_pkg::*;

    localparam int LIMIT = 8;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + LIMIT;

    logic i_Clk = 1'b0;
    logic i_Rst_n;
    logic i_Switch;
    logic o_Switch;
    logic o_Press;
    logic o_Release;
    logic o_Busy;

    switch_debounce #(
        .DEBOUNCE_LIMIT (LIMIT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Switch  (i_Switch),
        .o_Switch  (o_Switch),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Busy    (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe / edge monitor, sampled mid-cycle.
    int   press_tot = 0, rel_tot = 0, edge_tot = 0;
    int   overlap_viol = 0, repeat_viol = 0;
    logic prev_press = 1'b0, prev_rel = 1'b0, prev_sw = 1'b0;

    always @(negedge i_Clk) begin
        if (o_Press)              press_tot++;
        if (o_Release)            rel_tot++;
        if (o_Press && o_Release) overlap_viol++;
        if ((o_Press && prev_press) || (o_Release && prev_rel)) repeat_viol++;
        if (o_Switch !== prev_sw) edge_tot++;
        prev_press = o_Press;
        prev_rel   = o_Release;
        prev_sw    = o_Switch;
    end

    // Raw-input history since reset release; hist[k] is the input k edges before the latest.
    logic [15:0] hist;
    int          sva_errs = 0;

    always @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) hist <= '0;
        else          hist <= {hist[14:0], i_Switch};
    end

    a_rise_min: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
        $rose(o_Switch) |-> &hist[LAT-1:SYNC])
        else begin sva_errs++; $display("FAIL sva_rise_too_early at t=%0t", $time); end
    a_fall_min: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
        $fell(o_Switch) |-> ~|hist[LAT-1:SYNC])
        else begin sva_errs++; $display("FAIL sva_fall_too_early at t=%0t", $time); end
    a_rise_max: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
        (&hist[LAT:SYNC+1]) |-> o_Switch)
        else begin sva_errs++; $display("FAIL sva_rise_too_late at t=%0t", $time); end
    a_fall_max: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
        (~|hist[LAT:SYNC+1]) |-> !o_Switch)
        else begin sva_errs++; $display("FAIL sva_fall_too_late at t=%0t", $time); end

    // Counts posedges until o_Switch shows lvl; edges=-1 if the budget expires.
    task automatic wait_switch(input logic lvl, input int max, output int edges, output int busy_hi);
        edges   = -1;
        busy_hi = 0;
        for (int k = 1; k <= max; k++) begin
            @(posedge i_Clk);
            #1;
            if (o_Switch === lvl) begin
                edges = k;
                break;
            end
            if (o_Busy) busy_hi++;
        end
    endtask

    task automatic transition(input logic lvl);
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            i_Switch = lvl;
            repeat ($urandom_range(1, 5)) @(negedge i_Clk);
            i_Switch = !lvl;
            repeat ($urandom_range(1, 5)) @(negedge i_Clk);
        end
        i_Switch = lvl;
        repeat (LAT + 6) @(negedge i_Clk);
    endtask

    typedef struct {
        logic  lvl;
        int    cycles;
        logic  exp_sw;
        int    exp_press;
        int    exp_rel;
        string name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, busy_bad, e, b, p0, r0, ed0;

        vecs[0] = '{1'b0, 7,  1'b1, 0, 0, "glitch_lo_7"};
        vecs[1] = '{1'b1, 12, 1'b1, 0, 0, "recover_hi"};
        vecs[2] = '{1'b0, 9,  1'b1, 0, 0, "low_9_pending"};
        vecs[3] = '{1'b1, 6,  1'b0, 0, 1, "low_9_commit"};
        vecs[4] = '{1'b0, 10, 1'b0, 0, 0, "glitch_hi_6"};
        vecs[5] = '{1'b1, 3,  1'b0, 0, 0, "bounce_1"};
        vecs[6] = '{1'b0, 3,  1'b0, 0, 0, "bounce_2"};
        vecs[7] = '{1'b1, 3,  1'b0, 0, 0, "bounce_3"};
        vecs[8] = '{1'b0, 3,  1'b0, 0, 0, "bounce_4"};
        vecs[9] = '{1'b1, 14, 1'b1, 1, 0, "bounce_settle"};

        // 1. Reset behaviour
        i_Rst_n  = 1'b1;
        i_Switch = 1'b0;
        #2 i_Rst_n = 1'b0;
        #1;
        check("rst_switch", o_Switch, 0);
        check("rst_press", o_Press, 0);
        check("rst_release", o_Release, 0);
        check("rst_busy", o_Busy, 0);
        repeat (5) @(negedge i_Clk);
        i_Rst_n  = 1'b1;
        bad      = 0;
        busy_bad = 0;
        repeat (50) begin
            @(negedge i_Clk);
            if (o_Switch || o_Press || o_Release) bad++;
            if (o_Busy) busy_bad++;
        end
        check("idle_outputs_nonzero", bad, 0);
        check("idle_busy_high", busy_bad, 0);

        // 2. Clean press latency
        p0 = press_tot;
        i_Switch = 1'b1;
        wait_switch(1'b1, 30, e, b);
        check("press_latency", e, LAT);
        check("press_busy_cycles", b, LIMIT - 1);
        check("press_strobe_on_commit", o_Press, 1);
        check("press_busy_clear", o_Busy, 0);
        @(posedge i_Clk);
        #1;
        check("press_strobe_one_cycle", o_Press, 0);
        check("press_level_held", o_Switch, 1);
        repeat (4) @(negedge i_Clk);
        check("press_count", press_tot - p0, 1);

        // 3/4. Table of hold/glitch/bounce vectors
        foreach (vecs[i]) begin
            p0 = press_tot;
            r0 = rel_tot;
            i_Switch = vecs[i].lvl;
            repeat (vecs[i].cycles) @(negedge i_Clk);
            check({vecs[i].name, "_switch"}, o_Switch, vecs[i].exp_sw);
            check({vecs[i].name, "_press"}, press_tot - p0, vecs[i].exp_press);
            check({vecs[i].name, "_release"}, rel_tot - r0, vecs[i].exp_rel);
        end

        // 5. Reset mid-count and during the press strobe
        i_Switch = 1'b0;
        wait_switch(1'b0, 30, e, b);
        check("release_latency", e, LAT);
        check("release_strobe", o_Release, 1);
        @(negedge i_Clk);
        i_Switch = 1'b1;
        repeat (7) @(negedge i_Clk);
        check("midcount_busy", o_Busy, 1);
        check("midcount_cnt", dut.cnt_q, 5);
        i_Rst_n = 1'b0;
        #1;
        check("midrst_busy", o_Busy, 0);
        check("midrst_switch", o_Switch, 0);
        check("midrst_press", o_Press, 0);
        check("midrst_state", dut.state_q, STABLE_LO);
        check("midrst_cnt", dut.cnt_q, 0);
        repeat (2) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        wait_switch(1'b1, 30, e, b);
        check("high_at_release_latency", e, LAT);
        check("high_at_release_press", o_Press, 1);
        i_Rst_n = 1'b0;
        #1;
        check("strobe_rst_press", o_Press, 0);
        check("strobe_rst_switch", o_Switch, 0);
        check("strobe_rst_state", dut.state_q, STABLE_LO);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        wait_switch(1'b1, 30, e, b);
        check("redebounce_latency", e, LAT);
        check("redebounce_busy_cycles", b, LIMIT - 1);
        check("redebounce_press", o_Press, 1);
        repeat (3) @(negedge i_Clk);

        // 6. Random press/release with bounce
        p0  = press_tot;
        r0  = rel_tot;
        ed0 = edge_tot;
        for (int i = 0; i < 20; i++) begin
            transition(1'b0);
            check("rand_released", o_Switch, 0);
            transition(1'b1);
            check("rand_pressed", o_Switch, 1);
        end
        check("rand_press_count", press_tot - p0, 20);
        check("rand_release_count", rel_tot - r0, 20);
        check("rand_strobes_vs_edges", (press_tot - p0) + (rel_tot - r0), edge_tot - ed0);

        check("strobe_overlap", overlap_viol, 0);
        check("strobe_repeat", repeat_viol, 0);
        check("sva_latency", sva_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce
